mem_axi_arb: RTL and testbench
==============================

# mem_axi_arb

Two-master to one-slave AXI-lite arbiter that merges the core's instruction-fetch port (IFU, read-only) and load/store port (LSU, read/write) onto a single memory-side AXI-lite master port. Sits directly downstream of the core top and upstream of the memory/bus fabric. It arbitrates reads round-robin with one outstanding read at a time, and passes writes straight through. It holds off LSU reads while an LSU write is outstanding, to preserve LSU read-after-write ordering.

## Interface
- AW, 64, address width
- DW, 64, data width (strobe width DW/8)
- CLK  in  1  clock; all logic on rising edge
- RSTn  in  1  reset, synchronous and active-low; one clock domain
- IFU_ARADDR/ARPROT/ARVALID  in  AW/3/1  IFU read address
- IFU_ARREADY  out  1  IFU read address accept
- IFU_RDATA/RRESP/RVALID  out  DW/2/1  IFU read data
- IFU_RREADY  in  1
- LSU_ARADDR/ARPROT/ARVALID  in  AW/3/1;  LSU_ARREADY  out  1
- LSU_RDATA/RRESP/RVALID  out  DW/2/1;  LSU_RREADY  in  1
- LSU_AWADDR/AWPROT/AWVALID  in  AW/3/1;  LSU_AWREADY  out  1
- LSU_WDATA/WSTRB/WVALID  in  DW/DW÷8/1;  LSU_WREADY  out  1
- LSU_BRESP/BVALID  out  2/1;  LSU_BREADY  in  1
- MEM_AR*/AW*/W*  out; MEM_R*/B*  in, plus the matching READY signals: the memory-side AXI-lite master port, with the same widths as the LSU port

## Operation
- Read FSM has three states: IDLE, ADDR, DATA.
- IDLE: arbitrate among the eligible requesters.
  - IFU is eligible when IFU_ARVALID=1.
  - LSU is eligible when LSU_ARVALID=1 and wr_pend=0.
  - A single eligible requester wins.
  - On a tie, the requester not recorded in last_grant wins.
- In IDLE with a winner:
  - Assert the winner's ARREADY combinationally; this completes the master-side AR handshake.
  - Latch ADDR/PROT and owner; set last_grant=owner; go to ADDR.
- ADDR: MEM_ARVALID=1 with the latched address and prot, which stay stable. On MEM_ARREADY go to DATA.
- DATA:
  - Route MEM_RDATA/RRESP/RVALID to the owner; the non-owner's RVALID=0.
  - MEM_RREADY is the owner's RREADY.
  - On the R handshake go to IDLE.
- Both masters' ARREADY are 0 in ADDR and in DATA.
- Write path: AW, W and B pass combinationally between the LSU port and the MEM port, with one exception: MEM_AWVALID and LSU_AWREADY are gated to 0 while wr_pend=1.
- wr_pend register:
  - Set on the MEM AW handshake.
  - Cleared on the MEM B handshake.
  - If both happen in the same cycle, clear wins; that cycle cannot occur under the gate, but the rule is fixed anyway.
- At most one write is outstanding. Reads and writes may overlap: an IFU read may proceed during an LSU write.
- RESP values pass unmodified; the arbiter generates no errors.

## Timing
- Reset values: state=IDLE, wr_pend=0, last_grant=LSU (so IFU wins the first tie).
  - While RSTn=0: all *_ARREADY, MEM_ARVALID, IFU/LSU_RVALID and MEM_RREADY are forced 0; MEM_AWVALID, MEM_WVALID and LSU_BVALID are also 0.
- Read latency:
  - Master AR handshake at cycle t (IDLE).
  - MEM_ARVALID=1 from cycle t+1.
  - With MEM_ARREADY=1 at t+1, the earliest RVALID to the master is at t+2, passed combinationally.
- Throughput: one read per 3 cycles minimum, because IDLE is re-entered after every read.
- Back-to-back reads: IFU and LSU requesting continuously alternate I, L, I, L.
- A master holding ARVALID while the other is served keeps its request; it is granted in the next IDLE.
- LSU AR arriving while wr_pend=1 waits. It becomes eligible in the cycle after the B handshake.
- Reset asserted mid-transaction: the FSM returns to IDLE and wr_pend clears at the next edge. The in-flight MEM response is not tracked; system reset resets the slave too.
- No combinational path from any MEM_*READY to a MEM_*VALID on the read channel.

## Test plan
- Single IFU read:
  - Stimulus: IFU_ARADDR=0x8000_0000 at cycle 0; MEM_ARREADY=1; MEM returns RDATA=0x00000013_00000093 at cycle 2.
  - Required: IFU_ARREADY=1 at cycle 0, MEM_ARADDR=0x8000_0000 at cycle 1, IFU_RVALID at cycle 2 with that data, LSU_RVALID=0 throughout.
- Simultaneous AR from IFU (0x100) and LSU (0x200) after reset:
  - Required: IFU granted first; MEM sees 0x100, then 0x200; last_grant toggles.
  - With both held for 4 reads, grants run I, L, I, L.
- MEM_ARREADY stalled 5 cycles in ADDR:
  - Required: MEM_ARADDR stable; both master ARREADYs stay 0.
  - RVALID held with owner RREADY=0 for 3 cycles: data stable, FSM stays in DATA.
- LSU write to 0x300, then LSU read of 0x300 issued in the next cycle, with BVALID delayed 4 cycles:
  - Required: LSU_ARREADY=0 until the cycle after the B handshake.
  - An IFU read issued during the write completes normally.
- Second LSU AWVALID while wr_pend=1:
  - Required: MEM_AWVALID=0 and LSU_AWREADY=0 until B completes, then it is accepted.
- RSTn pulled low in DATA:
  - Required: next cycle, state is IDLE and all VALID/READY outputs are 0.
  - After release, an IFU read completes with cycle-2 latency.

Source files
------------

// File: rtl/mem_axi_arb.sv
// ---------------------------------------------------------------------------
// mem_axi_arb
//
// Merges the core's instruction-fetch port (IFU, read-only AXI-lite) and its
// load/store port (LSU, read/write AXI-lite) onto one memory-side AXI-lite
// master port.
//
// Reads : round-robin between IFU and LSU, one outstanding read at a time.
//         A three-state FSM (IDLE -> ADDR -> DATA) accepts the master AR in
//         IDLE, replays the latched address to memory in ADDR, and routes the
//         R beat back to the owner in DATA.
// Writes: AW/W/B pass straight through between LSU and MEM.  A single
//         outstanding write is tracked in wr_pend; while it is set a new AW is
//         held off and LSU reads are not eligible, which keeps LSU
//         read-after-write ordering intact.
//
// Parameters
//   AW  address width
//   DW  data width (strobe width DW/8)
//
// Ports
//   CLK, RSTn                  clock, synchronous active-low reset
//   IFU_AR*/IFU_R*             IFU read address / read data channels
//   LSU_AR*/LSU_R*             LSU read address / read data channels
//   LSU_AW*/LSU_W*/LSU_B*      LSU write address / write data / response
//   MEM_AR*/MEM_R*             memory-side read channels (master)
//   MEM_AW*/MEM_W*/MEM_B*      memory-side write channels (master)
//
// While RSTn=0 every handshake-control output of the arbiter is held low.
// ---------------------------------------------------------------------------
module mem_axi_arb #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic            CLK,
  input  logic            RSTn,

  // IFU read port
  input  logic [AW-1:0]   IFU_ARADDR,
  input  logic [2:0]      IFU_ARPROT,
  input  logic            IFU_ARVALID,
  output logic            IFU_ARREADY,
  output logic [DW-1:0]   IFU_RDATA,
  output logic [1:0]      IFU_RRESP,
  output logic            IFU_RVALID,
  input  logic            IFU_RREADY,

  // LSU read port
  input  logic [AW-1:0]   LSU_ARADDR,
  input  logic [2:0]      LSU_ARPROT,
  input  logic            LSU_ARVALID,
  output logic            LSU_ARREADY,
  output logic [DW-1:0]   LSU_RDATA,
  output logic [1:0]      LSU_RRESP,
  output logic            LSU_RVALID,
  input  logic            LSU_RREADY,

  // LSU write port
  input  logic [AW-1:0]   LSU_AWADDR,
  input  logic [2:0]      LSU_AWPROT,
  input  logic            LSU_AWVALID,
  output logic            LSU_AWREADY,
  input  logic [DW-1:0]   LSU_WDATA,
  input  logic [DW/8-1:0] LSU_WSTRB,
  input  logic            LSU_WVALID,
  output logic            LSU_WREADY,
  output logic [1:0]      LSU_BRESP,
  output logic            LSU_BVALID,
  input  logic            LSU_BREADY,

  // Memory-side read channels
  output logic [AW-1:0]   MEM_ARADDR,
  output logic [2:0]      MEM_ARPROT,
  output logic            MEM_ARVALID,
  input  logic            MEM_ARREADY,
  input  logic [DW-1:0]   MEM_RDATA,
  input  logic [1:0]      MEM_RRESP,
  input  logic            MEM_RVALID,
  output logic            MEM_RREADY,

  // Memory-side write channels
  output logic [AW-1:0]   MEM_AWADDR,
  output logic [2:0]      MEM_AWPROT,
  output logic            MEM_AWVALID,
  input  logic            MEM_AWREADY,
  output logic [DW-1:0]   MEM_WDATA,
  output logic [DW/8-1:0] MEM_WSTRB,
  output logic            MEM_WVALID,
  input  logic            MEM_WREADY,
  input  logic [1:0]      MEM_BRESP,
  input  logic            MEM_BVALID,
  output logic            MEM_BREADY
);

  // Read FSM encodings (kept as plain constants for legacy tooling).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Requester identities used for owner / last_grant.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          owner;
  logic          last_grant;
  logic          wr_pend;
  logic [AW-1:0] ar_addr;
  logic [2:0]    ar_prot;

  logic          in_idle;
  logic          in_addr;
  logic          in_data;
  logic          ifu_elig;
  logic          lsu_elig;
  logic          grant_ifu;
  logic          grant_lsu;
  logic          owner_rready;
  logic          r_hs;
  logic          aw_hs;
  logic          b_hs;

  // -------------------------------------------------------------------------
  // State decode, gated by reset so that every control output is low while
  // RSTn=0 regardless of the (not yet reset) register contents.
  // -------------------------------------------------------------------------
  assign in_idle = RSTn && (state == ST_IDLE);
  assign in_addr = RSTn && (state == ST_ADDR);
  assign in_data = RSTn && (state == ST_DATA);

  // -------------------------------------------------------------------------
  // Arbitration.  An LSU read is not eligible while its own write is still
  // outstanding.  On a tie the requester that did not win last time wins.
  // -------------------------------------------------------------------------
  assign ifu_elig  = IFU_ARVALID;
  assign lsu_elig  = LSU_ARVALID && !wr_pend;

  assign grant_ifu = ifu_elig && (!lsu_elig || (last_grant == OWN_LSU));
  assign grant_lsu = lsu_elig && (!ifu_elig || (last_grant == OWN_IFU));

  assign IFU_ARREADY = in_idle && grant_ifu;
  assign LSU_ARREADY = in_idle && grant_lsu;

  // -------------------------------------------------------------------------
  // Memory read address: driven purely from registered state so there is no
  // combinational path from MEM_ARREADY back to MEM_ARVALID.
  // -------------------------------------------------------------------------
  assign MEM_ARVALID = in_addr;
  assign MEM_ARADDR  = ar_addr;
  assign MEM_ARPROT  = ar_prot;

  // -------------------------------------------------------------------------
  // Read data routing to the owner of the outstanding read.
  // -------------------------------------------------------------------------
  assign owner_rready = (owner == OWN_LSU) ? LSU_RREADY : IFU_RREADY;

  assign MEM_RREADY = in_data && owner_rready;

  assign IFU_RDATA  = MEM_RDATA;
  assign IFU_RRESP  = MEM_RRESP;
  assign IFU_RVALID = in_data && (owner == OWN_IFU) && MEM_RVALID;

  assign LSU_RDATA  = MEM_RDATA;
  assign LSU_RRESP  = MEM_RRESP;
  assign LSU_RVALID = in_data && (owner == OWN_LSU) && MEM_RVALID;

  assign r_hs = in_data && MEM_RVALID && owner_rready;

  // -------------------------------------------------------------------------
  // Write path: straight pass-through, except that a new AW is blocked while
  // a previous write still awaits its B response.
  // -------------------------------------------------------------------------
  assign MEM_AWADDR  = LSU_AWADDR;
  assign MEM_AWPROT  = LSU_AWPROT;
  assign MEM_AWVALID = RSTn && LSU_AWVALID && !wr_pend;
  assign LSU_AWREADY = RSTn && MEM_AWREADY && !wr_pend;

  assign MEM_WDATA   = LSU_WDATA;
  assign MEM_WSTRB   = LSU_WSTRB;
  assign MEM_WVALID  = RSTn && LSU_WVALID;
  assign LSU_WREADY  = RSTn && MEM_WREADY;

  assign LSU_BRESP   = MEM_BRESP;
  assign LSU_BVALID  = RSTn && MEM_BVALID;
  assign MEM_BREADY  = RSTn && LSU_BREADY;

  assign aw_hs = MEM_AWVALID && MEM_AWREADY;
  assign b_hs  = MEM_BVALID && MEM_BREADY;

  // -------------------------------------------------------------------------
  // Read FSM next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_ifu || grant_lsu) begin
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (MEM_ARREADY) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= ST_IDLE;
      owner      <= OWN_IFU;
      last_grant <= OWN_LSU;
      ar_addr    <= '0;
      ar_prot    <= '0;
    end else begin
      state <= state_nxt;
      if (in_idle && (grant_ifu || grant_lsu)) begin
        owner      <= grant_lsu ? OWN_LSU : OWN_IFU;
        last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
        ar_addr    <= grant_lsu ? LSU_ARADDR : IFU_ARADDR;
        ar_prot    <= grant_lsu ? LSU_ARPROT : IFU_ARPROT;
      end
    end
  end

  // Outstanding-write flag.  A clear in the same cycle as a set wins, even
  // though the AW gate makes that combination unreachable.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_pend <= 1'b0;
    end else if (b_hs) begin
      wr_pend <= 1'b0;
    end else if (aw_hs) begin
      wr_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_axi_arb.sv
module tb_mem_axi_arb;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic            CLK;
  logic            RSTn;
  logic [AW-1:0]   IFU_ARADDR;
  logic [2:0]      IFU_ARPROT;
  logic            IFU_ARVALID;
  logic            IFU_ARREADY;
  logic [DW-1:0]   IFU_RDATA;
  logic [1:0]      IFU_RRESP;
  logic            IFU_RVALID;
  logic            IFU_RREADY;
  logic [AW-1:0]   LSU_ARADDR;
  logic [2:0]      LSU_ARPROT;
  logic            LSU_ARVALID;
  logic            LSU_ARREADY;
  logic [DW-1:0]   LSU_RDATA;
  logic [1:0]      LSU_RRESP;
  logic            LSU_RVALID;
  logic            LSU_RREADY;
  logic [AW-1:0]   LSU_AWADDR;
  logic [2:0]      LSU_AWPROT;
  logic            LSU_AWVALID;
  logic            LSU_AWREADY;
  logic [DW-1:0]   LSU_WDATA;
  logic [DW/8-1:0] LSU_WSTRB;
  logic            LSU_WVALID;
  logic            LSU_WREADY;
  logic [1:0]      LSU_BRESP;
  logic            LSU_BVALID;
  logic            LSU_BREADY;
  logic [AW-1:0]   MEM_ARADDR;
  logic [2:0]      MEM_ARPROT;
  logic            MEM_ARVALID;
  logic            MEM_ARREADY;
  logic [DW-1:0]   MEM_RDATA;
  logic [1:0]      MEM_RRESP;
  logic            MEM_RVALID;
  logic            MEM_RREADY;
  logic [AW-1:0]   MEM_AWADDR;
  logic [2:0]      MEM_AWPROT;
  logic            MEM_AWVALID;
  logic            MEM_AWREADY;
  logic [DW-1:0]   MEM_WDATA;
  logic [DW/8-1:0] MEM_WSTRB;
  logic            MEM_WVALID;
  logic            MEM_WREADY;
  logic [1:0]      MEM_BRESP;
  logic            MEM_BVALID;
  logic            MEM_BREADY;

  int tests;
  int failed;

  mem_axi_arb #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .IFU_ARADDR(IFU_ARADDR), .IFU_ARPROT(IFU_ARPROT), .IFU_ARVALID(IFU_ARVALID),
    .IFU_ARREADY(IFU_ARREADY), .IFU_RDATA(IFU_RDATA), .IFU_RRESP(IFU_RRESP),
    .IFU_RVALID(IFU_RVALID), .IFU_RREADY(IFU_RREADY),
    .LSU_ARADDR(LSU_ARADDR), .LSU_ARPROT(LSU_ARPROT), .LSU_ARVALID(LSU_ARVALID),
    .LSU_ARREADY(LSU_ARREADY), .LSU_RDATA(LSU_RDATA), .LSU_RRESP(LSU_RRESP),
    .LSU_RVALID(LSU_RVALID), .LSU_RREADY(LSU_RREADY),
    .LSU_AWADDR(LSU_AWADDR), .LSU_AWPROT(LSU_AWPROT), .LSU_AWVALID(LSU_AWVALID),
    .LSU_AWREADY(LSU_AWREADY), .LSU_WDATA(LSU_WDATA), .LSU_WSTRB(LSU_WSTRB),
    .LSU_WVALID(LSU_WVALID), .LSU_WREADY(LSU_WREADY), .LSU_BRESP(LSU_BRESP),
    .LSU_BVALID(LSU_BVALID), .LSU_BREADY(LSU_BREADY),
    .MEM_ARADDR(MEM_ARADDR), .MEM_ARPROT(MEM_ARPROT), .MEM_ARVALID(MEM_ARVALID),
    .MEM_ARREADY(MEM_ARREADY), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP),
    .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY),
    .MEM_AWADDR(MEM_AWADDR), .MEM_AWPROT(MEM_AWPROT), .MEM_AWVALID(MEM_AWVALID),
    .MEM_AWREADY(MEM_AWREADY), .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB),
    .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY), .MEM_BRESP(MEM_BRESP),
    .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    RSTn = 1'b0;
    IFU_ARADDR = '0; IFU_ARPROT = '0; IFU_ARVALID = 1'b0; IFU_RREADY = 1'b0;
    LSU_ARADDR = '0; LSU_ARPROT = '0; LSU_ARVALID = 1'b0; LSU_RREADY = 1'b0;
    LSU_AWADDR = '0; LSU_AWPROT = '0; LSU_AWVALID = 1'b0;
    LSU_WDATA = '0; LSU_WSTRB = '0; LSU_WVALID = 1'b0; LSU_BREADY = 1'b0;
    MEM_ARREADY = 1'b0; MEM_RDATA = '0; MEM_RRESP = '0; MEM_RVALID = 1'b0;
    MEM_AWREADY = 1'b0; MEM_WREADY = 1'b0; MEM_BRESP = '0; MEM_BVALID = 1'b0;

    // ---- reset state: outputs forced low even with requests present ----
    tick(); tick();
    IFU_ARVALID = 1'b1; LSU_AWVALID = 1'b1; MEM_BVALID = 1'b1; MEM_RVALID = 1'b1;
    #1;
    chk("rst_ifu_arready", 64'(IFU_ARREADY), 64'd0);
    chk("rst_mem_arvalid", 64'(MEM_ARVALID), 64'd0);
    chk("rst_mem_awvalid", 64'(MEM_AWVALID), 64'd0);
    chk("rst_lsu_bvalid",  64'(LSU_BVALID),  64'd0);
    chk("rst_ifu_rvalid",  64'(IFU_RVALID),  64'd0);
    IFU_ARVALID = 1'b0; LSU_AWVALID = 1'b0; MEM_BVALID = 1'b0; MEM_RVALID = 1'b0;
    tick();
    RSTn = 1'b1;
    tick();

    // ---- single IFU read ----
    IFU_ARVALID = 1'b1; IFU_ARADDR = 64'h8000_0000; IFU_RREADY = 1'b1;
    MEM_ARREADY = 1'b1;
    #1;
    chk("t1_ifu_arready_c0", 64'(IFU_ARREADY), 64'd1);
    chk("t1_lsu_rvalid_c0",  64'(LSU_RVALID),  64'd0);
    tick();
    IFU_ARVALID = 1'b0;
    #1;
    chk("t1_mem_arvalid_c1", 64'(MEM_ARVALID), 64'd1);
    chk("t1_mem_araddr_c1",  MEM_ARADDR,       64'h8000_0000);
    chk("t1_ifu_arready_c1", 64'(IFU_ARREADY), 64'd0);
    tick();
    MEM_RVALID = 1'b1; MEM_RDATA = 64'h0000_0013_0000_0093; MEM_RRESP = 2'b00;
    #1;
    chk("t1_ifu_rvalid_c2",  64'(IFU_RVALID),  64'd1);
    chk("t1_ifu_rdata_c2",   IFU_RDATA,        64'h0000_0013_0000_0093);
    chk("t1_lsu_rvalid_c2",  64'(LSU_RVALID),  64'd0);
    chk("t1_mem_rready_c2",  64'(MEM_RREADY),  64'd1);
    tick();
    MEM_RVALID = 1'b0;
    #1;
    chk("t1_ifu_rvalid_c3",  64'(IFU_RVALID),  64'd0);
    chk("t1_mem_arvalid_c3", 64'(MEM_ARVALID), 64'd0);

    // ---- simultaneous requests after reset: I, L, I, L ----
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    IFU_ARVALID = 1'b1; IFU_ARADDR = 64'h100;
    LSU_ARVALID = 1'b1; LSU_ARADDR = 64'h200;
    IFU_RREADY = 1'b1; LSU_RREADY = 1'b1;
    MEM_ARREADY = 1'b1; MEM_RVALID = 1'b1; MEM_RDATA = 64'h55AA;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_ifu_arready_%0d", i), 64'(IFU_ARREADY), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("t2_lsu_arready_%0d", i), 64'(LSU_ARREADY), (i % 2 == 0) ? 64'd0 : 64'd1);
      tick();
      #1;
      chk($sformatf("t2_mem_araddr_%0d", i), MEM_ARADDR, (i % 2 == 0) ? 64'h100 : 64'h200);
      chk($sformatf("t2_arready_addr_%0d", i), 64'({IFU_ARREADY, LSU_ARREADY}), 64'd0);
      tick();
      #1;
      chk($sformatf("t2_ifu_rvalid_%0d", i), 64'(IFU_RVALID), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("t2_lsu_rvalid_%0d", i), 64'(LSU_RVALID), (i % 2 == 0) ? 64'd0 : 64'd1);
      tick();
    end
    IFU_ARVALID = 1'b0; LSU_ARVALID = 1'b0; MEM_RVALID = 1'b0;

    // ---- ADDR stall 5 cycles, DATA held with RREADY=0 for 3 cycles ----
    tick();
    IFU_ARVALID = 1'b1; IFU_ARADDR = 64'h400;
    LSU_ARVALID = 1'b1; LSU_ARADDR = 64'h500;
    MEM_ARREADY = 1'b0;
    #1;
    chk("t3_ifu_arready", 64'(IFU_ARREADY), 64'd1);
    tick();
    IFU_ARVALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t3_stall_araddr_%0d", k), MEM_ARADDR, 64'h400);
      chk($sformatf("t3_stall_arvalid_%0d", k), 64'(MEM_ARVALID), 64'd1);
      chk($sformatf("t3_stall_arready_%0d", k), 64'({IFU_ARREADY, LSU_ARREADY}), 64'd0);
      tick();
    end
    MEM_ARREADY = 1'b1;
    tick();
    MEM_ARREADY = 1'b0;
    MEM_RVALID = 1'b1; MEM_RDATA = 64'hDEAD_BEEF_0000_0001; MEM_RRESP = 2'b10;
    IFU_RREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t3_hold_rvalid_%0d", k), 64'(IFU_RVALID), 64'd1);
      chk($sformatf("t3_hold_rdata_%0d", k), IFU_RDATA, 64'hDEAD_BEEF_0000_0001);
      chk($sformatf("t3_hold_rresp_%0d", k), 64'(IFU_RRESP), 64'd2);
      chk($sformatf("t3_hold_rready_%0d", k), 64'(MEM_RREADY), 64'd0);
      chk($sformatf("t3_hold_lsu_arready_%0d", k), 64'(LSU_ARREADY), 64'd0);
      tick();
    end
    IFU_RREADY = 1'b1;
    #1;
    chk("t3_release_rready", 64'(MEM_RREADY), 64'd1);
    tick();
    MEM_RVALID = 1'b0;
    #1;
    chk("t3_waiting_lsu_granted", 64'(LSU_ARREADY), 64'd1);
    tick();
    LSU_ARVALID = 1'b0; MEM_ARREADY = 1'b1;
    #1;
    chk("t3_lsu_araddr", MEM_ARADDR, 64'h500);
    tick();
    MEM_RVALID = 1'b1; MEM_RRESP = 2'b00;
    #1;
    chk("t3_lsu_rvalid", 64'(LSU_RVALID), 64'd1);
    chk("t3_ifu_rvalid_off", 64'(IFU_RVALID), 64'd0);
    tick();
    MEM_RVALID = 1'b0;

    // ---- LSU write 0x300, LSU read 0x300 held off until after B ----
    MEM_AWREADY = 1'b1; MEM_WREADY = 1'b1;
    LSU_AWVALID = 1'b1; LSU_AWADDR = 64'h300; LSU_AWPROT = 3'b010;
    LSU_WVALID = 1'b1; LSU_WDATA = 64'hCAFE_0000_1234_5678; LSU_WSTRB = 8'hF0;
    #1;
    chk("t4_mem_awvalid", 64'(MEM_AWVALID), 64'd1);
    chk("t4_mem_awaddr",  MEM_AWADDR,       64'h300);
    chk("t4_lsu_awready", 64'(LSU_AWREADY), 64'd1);
    chk("t4_mem_wdata",   MEM_WDATA,        64'hCAFE_0000_1234_5678);
    chk("t4_mem_wstrb",   64'(MEM_WSTRB),   64'hF0);
    chk("t4_lsu_wready",  64'(LSU_WREADY),  64'd1);
    tick();
    LSU_AWVALID = 1'b0; LSU_WVALID = 1'b0; LSU_BREADY = 1'b1;
    LSU_ARVALID = 1'b1; LSU_ARADDR = 64'h300;
    IFU_ARVALID = 1'b1; IFU_ARADDR = 64'h600;
    MEM_ARREADY = 1'b1;
    #1;
    chk("t4_c1_lsu_arready", 64'(LSU_ARREADY), 64'd0);
    chk("t4_c1_ifu_arready", 64'(IFU_ARREADY), 64'd1);
    tick();
    IFU_ARVALID = 1'b0;
    #1;
    chk("t4_c2_ifu_araddr", MEM_ARADDR, 64'h600);
    chk("t4_c2_lsu_arready", 64'(LSU_ARREADY), 64'd0);
    tick();
    MEM_RVALID = 1'b1; MEM_RDATA = 64'h1111;
    #1;
    chk("t4_c3_ifu_rvalid", 64'(IFU_RVALID), 64'd1);
    chk("t4_c3_ifu_rdata",  IFU_RDATA,       64'h1111);
    tick();
    MEM_RVALID = 1'b0;
    MEM_BVALID = 1'b1; MEM_BRESP = 2'b01;
    #1;
    chk("t4_c4_lsu_bvalid",  64'(LSU_BVALID),  64'd1);
    chk("t4_c4_lsu_bresp",   64'(LSU_BRESP),   64'd1);
    chk("t4_c4_mem_bready",  64'(MEM_BREADY),  64'd1);
    chk("t4_c4_lsu_arready", 64'(LSU_ARREADY), 64'd0);
    chk("t4_c4_mem_arvalid", 64'(MEM_ARVALID), 64'd0);
    tick();
    MEM_BVALID = 1'b0; MEM_BRESP = 2'b00;
    #1;
    chk("t4_c5_lsu_arready", 64'(LSU_ARREADY), 64'd1);
    tick();
    LSU_ARVALID = 1'b0;
    #1;
    chk("t4_lsu_araddr", MEM_ARADDR, 64'h300);
    tick();
    MEM_RVALID = 1'b1;
    #1;
    chk("t4_lsu_rvalid", 64'(LSU_RVALID), 64'd1);
    tick();
    MEM_RVALID = 1'b0;

    // ---- second AW held off while a write is pending ----
    LSU_AWVALID = 1'b1; LSU_AWADDR = 64'h700; LSU_WVALID = 1'b1;
    #1;
    chk("t5_first_awvalid", 64'(MEM_AWVALID), 64'd1);
    tick();
    LSU_WVALID = 1'b0; LSU_AWADDR = 64'h708;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t5_gate_awvalid_%0d", k), 64'(MEM_AWVALID), 64'd0);
      chk($sformatf("t5_gate_awready_%0d", k), 64'(LSU_AWREADY), 64'd0);
      tick();
    end
    MEM_BVALID = 1'b1;
    #1;
    chk("t5_bcycle_awvalid", 64'(MEM_AWVALID), 64'd0);
    tick();
    MEM_BVALID = 1'b0;
    #1;
    chk("t5_after_awvalid", 64'(MEM_AWVALID), 64'd1);
    chk("t5_after_awready", 64'(LSU_AWREADY), 64'd1);
    chk("t5_after_awaddr",  MEM_AWADDR,       64'h708);
    tick();
    LSU_AWVALID = 1'b0;
    MEM_BVALID = 1'b1;
    tick();
    MEM_BVALID = 1'b0;

    // ---- reset in DATA with a write outstanding ----
    IFU_ARVALID = 1'b1; IFU_ARADDR = 64'h900;
    LSU_AWVALID = 1'b1; LSU_AWADDR = 64'hA00;
    #1;
    chk("t6_ifu_arready", 64'(IFU_ARREADY), 64'd1);
    tick();
    IFU_ARVALID = 1'b0; LSU_AWVALID = 1'b0;
    tick();
    MEM_RVALID = 1'b1;
    #1;
    chk("t6_data_rvalid", 64'(IFU_RVALID), 64'd1);
    RSTn = 1'b0;
    #1;
    chk("t6_rst_rvalid_forced", 64'(IFU_RVALID), 64'd0);
    chk("t6_rst_rready_forced", 64'(MEM_RREADY), 64'd0);
    tick();
    #1;
    chk("t6_rst_outputs",
        64'({IFU_ARREADY, LSU_ARREADY, MEM_ARVALID, IFU_RVALID, LSU_RVALID,
             MEM_RREADY, MEM_AWVALID, LSU_AWREADY, MEM_WVALID, LSU_WREADY,
             LSU_BVALID, MEM_BREADY}), 64'd0);
    RSTn = 1'b1;
    MEM_RVALID = 1'b0;
    IFU_ARVALID = 1'b1; IFU_ARADDR = 64'hB00;
    #1;
    chk("t6_post_ifu_arready", 64'(IFU_ARREADY), 64'd1);
    tick();
    IFU_ARVALID = 1'b0;
    #1;
    chk("t6_post_arvalid", 64'(MEM_ARVALID), 64'd1);
    chk("t6_post_araddr",  MEM_ARADDR,       64'hB00);
    tick();
    MEM_RVALID = 1'b1; MEM_RDATA = 64'h2222;
    #1;
    chk("t6_post_rvalid", 64'(IFU_RVALID), 64'd1);
    chk("t6_post_rdata",  IFU_RDATA,       64'h2222);
    tick();
    MEM_RVALID = 1'b0;
    MEM_AWREADY = 1'b0;
    LSU_AWVALID = 1'b1; LSU_ARVALID = 1'b1; LSU_ARADDR = 64'hC00;
    #1;
    chk("t6_wr_pend_cleared_aw", 64'(MEM_AWVALID), 64'd1);
    chk("t6_wr_pend_cleared_ar", 64'(LSU_ARREADY), 64'd1);
    tick();
    LSU_AWVALID = 1'b0; LSU_ARVALID = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
